// File: rtl/sim_controller_if.sv
// Control/status bundle between the run sequencer and its environment.
// The slave modport is the sequencer side; master is the driving side.
interface sim_controller_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             start;
  logic             stop_req;
  logic             eof;
  logic             reading_clk;
  logic             writing_clk;
  logic             enable;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] written_cnt;
  logic             busy;
  logic             done;
  logic             timeout;

  modport slave (
    input  start, stop_req, eof, reading_clk, writing_clk,
    output enable, sample_cnt, written_cnt, busy, done, timeout
  );

  modport master (
    output start, stop_req, eof, reading_clk, writing_clk,
    input  enable, sample_cnt, written_cnt, busy, done, timeout
  );
endinterface

// File: rtl/sim_controller.sv
// Run sequencer: warm-up with the clock driver disabled, run until budget/eof/stop/watchdog,
// then drain outstanding writes and flag completion.
module sim_controller #(
  parameter int unsigned WARMUP_CYCLES  = 16,
  parameter int unsigned MAX_SAMPLES    = 1024,
  parameter int unsigned DRAIN_SAMPLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic          clk,
  input  logic          rst,
  sim_controller_if.slave bus
);

  localparam int unsigned WM_W = (WARMUP_CYCLES > 1)  ? $clog2(WARMUP_CYCLES)      : 1;
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned DR_W = (DRAIN_SAMPLES > 0)  ? $clog2(DRAIN_SAMPLES + 1)  : 1;

  typedef enum logic [2:0] {IDLE, WARMUP, RUN, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic             prev_r, prev_w, rise_r, rise_w;
  logic [WM_W-1:0]  warm_cnt;
  logic [WD_W-1:0]  wdog, wdog_n;
  logic [DR_W-1:0]  drain_cnt, drain_n;
  logic [CNT_W-1:0] sample_n, written_n;
  logic             exit_run, wd_expired;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign rise_r    = bus.reading_clk & ~prev_r;
  assign rise_w    = bus.writing_clk & ~prev_w;
  assign sample_n  = sat_inc(bus.sample_cnt, rise_r);
  assign written_n = sat_inc(bus.written_cnt, rise_w);

  // Watchdog and drain counters saturate at their limits, so equality is a safe terminal test.
  assign wdog_n  = rise_r ? '0 :
                   (wdog == WD_W'(TIMEOUT_CYCLES)) ? wdog : wdog + 1'b1;
  assign drain_n = (rise_w && (drain_cnt != DR_W'(DRAIN_SAMPLES))) ? drain_cnt + 1'b1 : drain_cnt;

  assign wd_expired = !rise_r && (wdog_n == WD_W'(TIMEOUT_CYCLES));
  assign exit_run   = bus.eof || bus.stop_req ||
                      ((MAX_SAMPLES != 0) && (64'(sample_n) == 64'(MAX_SAMPLES)));

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (bus.start) state_n = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
      WARMUP:     if (warm_cnt == WM_W'(WARMUP_CYCLES - 1)) state_n = RUN;
      RUN: begin
        if (wd_expired)    state_n = DONE;
        else if (exit_run) state_n = DRAIN;
      end
      DRAIN:      if (drain_n == DR_W'(DRAIN_SAMPLES)) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      prev_r          <= 1'b0;
      prev_w          <= 1'b0;
      warm_cnt        <= '0;
      wdog            <= '0;
      drain_cnt       <= '0;
      bus.enable      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.sample_cnt  <= '0;
      bus.written_cnt <= '0;
    end else begin
      state      <= state_n;
      prev_r     <= bus.reading_clk;
      prev_w     <= bus.writing_clk;
      // Outputs follow the next state so they line up with the state register.
      bus.enable <= (state_n == RUN) || (state_n == DRAIN);
      bus.busy   <= (state_n == WARMUP) || (state_n == RUN) || (state_n == DRAIN);
      bus.done   <= (state_n == DONE);
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            bus.sample_cnt  <= '0;
            bus.written_cnt <= '0;
            bus.timeout     <= 1'b0;
            wdog            <= '0;
            warm_cnt        <= '0;
          end
        end
        WARMUP: warm_cnt <= warm_cnt + 1'b1;
        RUN: begin
          bus.sample_cnt  <= sample_n;
          bus.written_cnt <= written_n;
          wdog            <= wdog_n;
          drain_cnt       <= '0;
          if (wd_expired) bus.timeout <= 1'b1;
        end
        DRAIN: begin
          bus.written_cnt <= written_n;
          drain_cnt       <= drain_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_controller.sv
// Directed bench for sim_controller: three instances cover the nominal, unlimited-budget
// and zero-warm-up/zero-drain/narrow-counter configurations.
module tb_sim_controller;

  logic clk;
  logic rst;
  logic rd, wr, eof_s, stop_s;
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  sim_controller_if #(.CNT_W(32)) if_a ();
  sim_controller_if #(.CNT_W(32)) if_b ();
  sim_controller_if #(.CNT_W(4))  if_c ();

  assign if_a.reading_clk = rd;
  assign if_a.writing_clk = wr;
  assign if_a.eof         = eof_s;
  assign if_a.stop_req    = stop_s;
  assign if_b.reading_clk = rd;
  assign if_b.writing_clk = wr;
  assign if_b.eof         = eof_s;
  assign if_b.stop_req    = stop_s;
  assign if_c.reading_clk = rd;
  assign if_c.writing_clk = wr;
  assign if_c.eof         = eof_s;
  assign if_c.stop_req    = stop_s;

  sim_controller #(
    .WARMUP_CYCLES(16), .MAX_SAMPLES(8), .DRAIN_SAMPLES(4), .TIMEOUT_CYCLES(50), .CNT_W(32)
  ) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));

  sim_controller #(
    .WARMUP_CYCLES(2), .MAX_SAMPLES(0), .DRAIN_SAMPLES(4), .TIMEOUT_CYCLES(1000), .CNT_W(32)
  ) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  sim_controller #(
    .WARMUP_CYCLES(0), .MAX_SAMPLES(0), .DRAIN_SAMPLES(0), .TIMEOUT_CYCLES(1000), .CNT_W(4)
  ) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic r, input logic w);
    rd = r;
    wr = w;
    step();
    rd = 1'b0;
    wr = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; eof_s = 1'b0; stop_s = 1'b0;
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
    steps(2);
    rst = 1'b0;
    step();

    chk("rst_enable",  if_a.enable, 1'b0);
    chk("rst_busy",    if_a.busy, 1'b0);
    chk("rst_done",    if_a.done, 1'b0);
    chk("rst_timeout", if_a.timeout, 1'b0);
    chk("rst_sample",  if_a.sample_cnt, 32'd0);
    chk("rst_written", if_a.written_cnt, 32'd0);

    // Nominal run: warm-up latency, sample budget, drain.
    if_a.start = 1'b1; step(); if_a.start = 1'b0;
    chk("t1_busy_warmup",   if_a.busy, 1'b1);
    chk("t1_enable_warmup", if_a.enable, 1'b0);
    steps(15);
    chk("t1_enable_pre", if_a.enable, 1'b0);
    step();
    chk("t1_enable_on", if_a.enable, 1'b1);
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b1);
    chk("t1_sample_max",  if_a.sample_cnt, 32'd8);
    chk("t1_written_run", if_a.written_cnt, 32'd8);
    chk("t1_enable_drain", if_a.enable, 1'b1);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
    chk("t1_done_pre", if_a.done, 1'b0);
    rd = 1'b1; wr = 1'b1; step();
    chk("t1_done",     if_a.done, 1'b1);
    chk("t1_enable_off", if_a.enable, 1'b0);
    chk("t1_busy_off", if_a.busy, 1'b0);
    chk("t1_written",  if_a.written_cnt, 32'd12);
    chk("t1_sample_frozen", if_a.sample_cnt, 32'd8);
    rd = 1'b0; wr = 1'b0; step();

    // eof coinciding with a reading rise: the edge still counts, then counting stops.
    if_a.start = 1'b1; step(); if_a.start = 1'b0;
    chk("t2_sample_clr",  if_a.sample_cnt, 32'd0);
    chk("t2_written_clr", if_a.written_cnt, 32'd0);
    chk("t2_done_clr",    if_a.done, 1'b0);
    steps(16);
    chk("t2_enable_on", if_a.enable, 1'b1);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    chk("t2_sample5", if_a.sample_cnt, 32'd5);
    rd = 1'b1; eof_s = 1'b1; step();
    chk("t2_sample_eof", if_a.sample_cnt, 32'd6);
    chk("t2_enable_drain", if_a.enable, 1'b1);
    rd = 1'b0; eof_s = 1'b0; step();
    pulse(1'b1, 1'b0);
    chk("t2_sample_frozen", if_a.sample_cnt, 32'd6);
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1);
    chk("t2_done",    if_a.done, 1'b1);
    chk("t2_written", if_a.written_cnt, 32'd4);

    // Watchdog with no reading rises.
    if_a.start = 1'b1; step(); if_a.start = 1'b0;
    steps(16);
    chk("t3_enable_on", if_a.enable, 1'b1);
    steps(49);
    chk("t3_timeout_pre", if_a.timeout, 1'b0);
    chk("t3_enable_pre",  if_a.enable, 1'b1);
    step();
    chk("t3_timeout",    if_a.timeout, 1'b1);
    chk("t3_done",       if_a.done, 1'b1);
    chk("t3_enable_off", if_a.enable, 1'b0);
    chk("t3_written_nodrain", if_a.written_cnt, 32'd0);
    if_a.start = 1'b1; step(); if_a.start = 1'b0;
    chk("t3_timeout_clr", if_a.timeout, 1'b0);
    chk("t3_busy_restart", if_a.busy, 1'b1);

    // Reset in the middle of a run.
    steps(16);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
    chk("t4_sample3", if_a.sample_cnt, 32'd3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t4_enable", if_a.enable, 1'b0);
    chk("t4_busy",   if_a.busy, 1'b0);
    chk("t4_done",   if_a.done, 1'b0);
    chk("t4_sample", if_a.sample_cnt, 32'd0);
    chk("t4_written", if_a.written_cnt, 32'd0);
    if_a.start = 1'b1; step(); if_a.start = 1'b0;
    steps(16);
    chk("t4_enable_rerun", if_a.enable, 1'b1);
    pulse(1'b1, 1'b0);
    chk("t4_sample_rerun", if_a.sample_cnt, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;

    // Unlimited budget, stop request, start ignored during drain.
    if_b.start = 1'b1; step(); if_b.start = 1'b0;
    step();
    chk("t5_enable_pre", if_b.enable, 1'b0);
    step();
    chk("t5_enable_on", if_b.enable, 1'b1);
    for (int i = 0; i < 20; i++) pulse(1'b1, 1'b1);
    chk("t5_sample20", if_b.sample_cnt, 32'd20);
    stop_s = 1'b1; step(); stop_s = 1'b0;
    chk("t5_enable_drain", if_b.enable, 1'b1);
    if_b.start = 1'b1; step(); if_b.start = 1'b0;
    chk("t5_start_ignored", if_b.sample_cnt, 32'd20);
    chk("t5_busy_drain", if_b.busy, 1'b1);
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1);
    chk("t5_done",    if_b.done, 1'b1);
    chk("t5_written", if_b.written_cnt, 32'd24);
    chk("t5_sample",  if_b.sample_cnt, 32'd20);

    // Zero warm-up, zero drain, 4-bit saturating counters.
    if_c.start = 1'b1; step(); if_c.start = 1'b0;
    chk("t6_enable_now", if_c.enable, 1'b1);
    for (int i = 0; i < 20; i++) pulse(1'b1, 1'b1);
    chk("t6_sample_sat",  if_c.sample_cnt, 4'd15);
    chk("t6_written_sat", if_c.written_cnt, 4'd15);
    stop_s = 1'b1; step(); stop_s = 1'b0;
    chk("t6_enable_drain", if_c.enable, 1'b1);
    chk("t6_done_pre", if_c.done, 1'b0);
    step();
    chk("t6_done",       if_c.done, 1'b1);
    chk("t6_enable_off", if_c.enable, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
